// File: rtl/mips_mc_hs.sv
`default_nettype none
// ============================================================================
// mips_mc_hs : multi-cycle MIPS32-subset core with req/ack memory handshakes.
//              Optional MUL (SPECIAL2) enabled by defining MIPS_MUL_EN.
// Revision   : 1.0
// ============================================================================
module mips_mc_hs #(
  parameter logic [31:0] PC_INIT  = 32'h0,
  parameter logic [31:0] SP_INIT  = 32'h0,
  parameter logic [31:0] RA_INIT  = 32'h0,
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [31:0]         dmem_wdata,
  input  logic                dmem_ack,
  input  logic [31:0]         dmem_rdata,
  output logic [RETIRE_W-1:0] retired,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4
  } state_t;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] FN_SLL      = 6'b000000;
  localparam logic [5:0] FN_JR       = 6'b001000;
  localparam logic [5:0] FN_ADDU     = 6'b100001;
  localparam logic [5:0] FN_SUBU     = 6'b100011;
  localparam logic [5:0] FN_SLT      = 6'b101010;
`ifdef MIPS_MUL_EN
  localparam logic [5:0] FN_MUL      = 6'b000010;
`endif

  state_t      state, state_nx;
  logic [31:0] pc, ir, rs_val, rt_val, imm_sx, pc4, alu_q, npc_q, mdr;
  logic [4:0]  wa_q;
  logic        we_q, ld_q, st_q, ill_q;
  logic [31:0] regs [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];

  logic [31:0] ex_res, ex_npc, br_tgt;
  logic [4:0]  ex_wa;
  logic        ex_we, ex_ld, ex_st, ex_ill;
  assign br_tgt = pc4 + {imm_sx[29:0], 2'b00};

  always_comb begin
    ex_res = 32'h0;
    ex_npc = pc4;
    ex_wa  = rd;
    ex_we  = 1'b0;
    ex_ld  = 1'b0;
    ex_st  = 1'b0;
    ex_ill = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU: begin ex_res = rs_val + rt_val; ex_we = 1'b1; end
          FN_SUBU: begin ex_res = rs_val - rt_val; ex_we = 1'b1; end
          FN_SLT:  begin ex_res = {31'b0, $signed(rs_val) < $signed(rt_val)}; ex_we = 1'b1; end
          FN_SLL:  begin ex_res = rt_val << shamt; ex_we = 1'b1; end
          FN_JR:   ex_npc = rs_val;
          default: ex_ill = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
`ifdef MIPS_MUL_EN
        if (funct == FN_MUL) begin
          ex_res = rs_val * rt_val;
          ex_we  = 1'b1;
        end else begin
          ex_ill = 1'b1;
        end
`else
        ex_ill = 1'b1;
`endif
      end
      OP_ADDIU: begin ex_res = rs_val + imm_sx; ex_wa = rt; ex_we = 1'b1; end
      OP_SLTI:  begin ex_res = {31'b0, $signed(rs_val) < $signed(imm_sx)}; ex_wa = rt; ex_we = 1'b1; end
      OP_LW:    begin ex_res = rs_val + imm_sx; ex_wa = rt; ex_we = 1'b1; ex_ld = 1'b1; end
      OP_SW:    begin ex_res = rs_val + imm_sx; ex_st = 1'b1; end
      OP_BEQ:   if (rs_val == rt_val) ex_npc = br_tgt;
      OP_BNE:   if (rs_val != rt_val) ex_npc = br_tgt;
      OP_J:     ex_npc = {pc4[31:28], ir[25:0], 2'b00};
      OP_JAL: begin
        ex_npc = {pc4[31:28], ir[25:0], 2'b00};
        ex_res = pc4;
        ex_wa  = 5'd31;
        ex_we  = 1'b1;
      end
      default: ex_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  // Outputs are gated by reset so an aborted handshake drops immediately.
  always_comb begin
    state_nx   = state;
    imem_req   = 1'b0;
    imem_addr  = 32'h0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req  = ~reset;
        imem_addr = reset ? 32'h0 : pc;
        if (imem_ack) state_nx = S_DECODE;
      end
      S_DECODE:  state_nx = S_EXECUTE;
      S_EXECUTE: state_nx = S_MEM;
      S_MEM: begin
        if ((ld_q || st_q) && !reset) begin
          dmem_req   = 1'b1;
          dmem_we    = st_q;
          dmem_addr  = alu_q & 32'hFFFF_FFFC;
          dmem_wdata = st_q ? rt_val : 32'h0;
        end
        if (!(ld_q || st_q) || dmem_ack) state_nx = S_WB;
      end
      S_WB: begin
        illegal  = ill_q & ~reset;
        state_nx = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= PC_INIT;
      ir      <= 32'h0;
      rs_val  <= 32'h0;
      rt_val  <= 32'h0;
      imm_sx  <= 32'h0;
      pc4     <= 32'h0;
      alu_q   <= 32'h0;
      npc_q   <= 32'h0;
      mdr     <= 32'h0;
      wa_q    <= 5'd0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      ill_q   <= 1'b0;
      retired <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      regs[29] <= SP_INIT;
      regs[31] <= RA_INIT;
    end else begin
      case (state)
        S_FETCH: if (imem_ack) ir <= imem_rdata;
        S_DECODE: begin
          rs_val <= (rs == 5'd0) ? 32'h0 : regs[rs];
          rt_val <= (rt == 5'd0) ? 32'h0 : regs[rt];
          imm_sx <= {{16{ir[15]}}, ir[15:0]};
          pc4    <= pc + 32'd4;
        end
        S_EXECUTE: begin
          alu_q <= ex_res;
          npc_q <= ex_npc;
          wa_q  <= ex_wa;
          we_q  <= ex_we;
          ld_q  <= ex_ld;
          st_q  <= ex_st;
          ill_q <= ex_ill;
        end
        S_MEM: if (ld_q && dmem_ack) mdr <= dmem_rdata;
        S_WB: begin
          if (we_q && wa_q != 5'd0) regs[wa_q] <= ld_q ? mdr : alu_q;
          pc      <= npc_q;
          retired <= retired + RETIRE_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_hs.sv
`default_nettype none
// ============================================================================
// tb_mips_mc_hs : directed self-checking bench for mips_mc_hs.
// Revision      : 1.0
// ============================================================================
module tb_mips_mc_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, illegal;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] retired;

  mips_mc_hs #(
    .PC_INIT(32'h400), .SP_INIT(32'h7FFC), .RA_INIT(32'h1234), .RETIRE_W(32)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .retired(retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [1024];
  logic [31:0] ld_data;
  logic [31:0] st_addr [8];
  logic [31:0] st_data [8];
  int imem_lat, dmem_lat, icnt, dcnt, st_cnt, ill_cnt, overlap;
  logic tb_clr;
  int ncmp = 0, nerr = 0;

  // Memory models: ack after a programmable number of wait cycles.
  assign imem_ack   = imem_req && (icnt == imem_lat);
  assign imem_rdata = imem[imem_addr[11:2]];
  assign dmem_ack   = dmem_req && (dcnt == dmem_lat);
  assign dmem_rdata = ld_data;

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (tb_clr) begin
      st_cnt  <= 0;
      ill_cnt <= 0;
    end else begin
      if (dmem_req && dmem_ack && dmem_we) begin
        st_addr[st_cnt[2:0]] <= dmem_addr;
        st_data[st_cnt[2:0]] <= dmem_wdata;
        st_cnt <= st_cnt + 1;
      end
      if (illegal) ill_cnt <= ill_cnt + 1;
    end
    if (imem_req && dmem_req) overlap <= overlap + 1;
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds reset for two edges and releases it on a falling edge.
  task automatic start();
    reset = 1'b1; tb_clr = 1'b1;
    cyc(2);
    reset = 1'b0; tb_clr = 1'b0;
  endtask

  task automatic test_reset();
    clear_prog();
    imem[32'h400 >> 2] = enc_i(6'h2B, 5'd0, 5'd29, 16'h0000);
    imem[32'h404 >> 2] = enc_i(6'h2B, 5'd0, 5'd31, 16'h0004);
    reset = 1'b1; tb_clr = 1'b1;
    cyc(2);
    ncmp++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
    ncmp++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL rst_dmem_req: got %b want 0", dmem_req); end
    ncmp++; if (illegal !== 1'b0) begin nerr++; $display("FAIL rst_illegal: got %b want 0", illegal); end
    ncmp++; if (retired !== 32'h0) begin nerr++; $display("FAIL rst_retired: got %h want 0", retired); end
    ncmp++; if (imem_addr !== 32'h0) begin nerr++; $display("FAIL rst_imem_addr: got %h want 0", imem_addr); end
    reset = 1'b0; tb_clr = 1'b0;
    #1;
    ncmp++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL first_req: got %b want 1", imem_req); end
    ncmp++; if (imem_addr !== 32'h400) begin nerr++; $display("FAIL first_addr: got %h want 400", imem_addr); end
    cyc(10);
    ncmp++; if (st_cnt !== 2) begin nerr++; $display("FAIL sp_ra_nstores: got %0d want 2", st_cnt); end
    ncmp++; if (st_addr[0] !== 32'h0 || st_data[0] !== 32'h7FFC) begin nerr++; $display("FAIL sp_store: got %h@%h want 00007ffc@0", st_data[0], st_addr[0]); end
    ncmp++; if (st_addr[1] !== 32'h4 || st_data[1] !== 32'h1234) begin nerr++; $display("FAIL ra_store: got %h@%h want 00001234@4", st_data[1], st_addr[1]); end
  endtask

  task automatic test_slt();
    clear_prog();
    imem[32'h400 >> 2] = enc_i(6'h09, 5'd0, 5'd1, 16'hFFFB);
    imem[32'h404 >> 2] = enc_i(6'h0A, 5'd1, 5'd2, 16'h0001);
    imem[32'h408 >> 2] = enc_r(5'd0, 5'd1, 5'd3, 5'd0, 6'h2A);
    start();
    cyc(14);
    ncmp++; if (retired !== 32'd2) begin nerr++; $display("FAIL slt_retired14: got %0d want 2", retired); end
    cyc(1);
    ncmp++; if (retired !== 32'd3) begin nerr++; $display("FAIL slt_retired15: got %0d want 3", retired); end
    ncmp++; if (dut.regs[1] !== 32'hFFFFFFFB) begin nerr++; $display("FAIL addiu_neg: got %h want fffffffb", dut.regs[1]); end
    ncmp++; if (dut.regs[2] !== 32'h1) begin nerr++; $display("FAIL slti: got %h want 1", dut.regs[2]); end
    ncmp++; if (dut.regs[3] !== 32'h0) begin nerr++; $display("FAIL slt: got %h want 0", dut.regs[3]); end
  endtask

  task automatic test_alu();
    clear_prog();
    imem[32'h400 >> 2] = enc_i(6'h09, 5'd0, 5'd5, 16'h0007);
    imem[32'h404 >> 2] = enc_i(6'h09, 5'd0, 5'd6, 16'hFFFD);
    imem[32'h408 >> 2] = enc_r(5'd5, 5'd6, 5'd7, 5'd0, 6'h21);
    imem[32'h40C >> 2] = enc_r(5'd5, 5'd6, 5'd8, 5'd0, 6'h23);
    imem[32'h410 >> 2] = enc_r(5'd0, 5'd5, 5'd9, 5'd4, 6'h00);
    imem[32'h414 >> 2] = {6'b011100, 5'd5, 5'd6, 5'd4, 5'd0, 6'b000010};
    start();
    cyc(30);
    ncmp++; if (retired !== 32'd6) begin nerr++; $display("FAIL alu_retired: got %0d want 6", retired); end
    ncmp++; if (dut.regs[7] !== 32'h4) begin nerr++; $display("FAIL addu: got %h want 4", dut.regs[7]); end
    ncmp++; if (dut.regs[8] !== 32'hA) begin nerr++; $display("FAIL subu: got %h want a", dut.regs[8]); end
    ncmp++; if (dut.regs[9] !== 32'h70) begin nerr++; $display("FAIL sll: got %h want 70", dut.regs[9]); end
`ifdef MIPS_MUL_EN
    ncmp++; if (dut.regs[4] !== 32'hFFFFFFEB) begin nerr++; $display("FAIL mul: got %h want ffffffeb", dut.regs[4]); end
    ncmp++; if (ill_cnt !== 0) begin nerr++; $display("FAIL mul_illegal: got %0d want 0", ill_cnt); end
`else
    ncmp++; if (dut.regs[4] !== 32'h0) begin nerr++; $display("FAIL mul_off_rd: got %h want 0", dut.regs[4]); end
    ncmp++; if (ill_cnt !== 1) begin nerr++; $display("FAIL mul_off_illegal: got %0d want 1", ill_cnt); end
`endif
  endtask

  task automatic test_wait_states();
    clear_prog();
    imem[32'h400 >> 2] = enc_i(6'h23, 5'd0, 5'd10, 16'h0013);
    imem_lat = 3; dmem_lat = 2; ld_data = 32'hCAFEBABE;
    start();
    cyc(2);
    ncmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin nerr++; $display("FAIL wait_fetch_hold: got req=%b addr=%h want 1/400", imem_req, imem_addr); end
    cyc(4);
    ncmp++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h10 || dmem_we !== 1'b0) begin nerr++; $display("FAIL wait_mem_k6: got req=%b addr=%h we=%b want 1/10/0", dmem_req, dmem_addr, dmem_we); end
    ncmp++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL wait_no_ireq: got %b want 0", imem_req); end
    cyc(1);
    ncmp++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h10) begin nerr++; $display("FAIL wait_mem_k7: got req=%b addr=%h want 1/10", dmem_req, dmem_addr); end
    cyc(2);
    ncmp++; if (dmem_req !== 1'b0 || retired !== 32'd0) begin nerr++; $display("FAIL wait_wb_k9: got req=%b ret=%0d want 0/0", dmem_req, retired); end
    cyc(1);
    ncmp++; if (retired !== 32'd1) begin nerr++; $display("FAIL wait_retired10: got %0d want 1", retired); end
    ncmp++; if (dut.regs[10] !== 32'hCAFEBABE) begin nerr++; $display("FAIL lw_data: got %h want cafebabe", dut.regs[10]); end
    ncmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h404) begin nerr++; $display("FAIL wait_next_fetch: got req=%b addr=%h want 1/404", imem_req, imem_addr); end
    imem_lat = 0; dmem_lat = 0;
  endtask

  task automatic test_branches();
    clear_prog();
    imem[32'h400 >> 2] = enc_j(6'h02, 26'h40);
    imem[32'h100 >> 2] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    start();
    cyc(5);
    ncmp++; if (imem_addr !== 32'h100) begin nerr++; $display("FAIL j_target: got %h want 100", imem_addr); end
    cyc(5);
    ncmp++; if (imem_addr !== 32'h100) begin nerr++; $display("FAIL beq_taken: got %h want 100", imem_addr); end
    clear_prog();
    imem[32'h400 >> 2] = enc_j(6'h02, 26'h40);
    imem[32'h100 >> 2] = enc_i(6'h05, 5'd0, 5'd0, 16'hFFFF);
    imem[32'h104 >> 2] = enc_j(6'h02, 26'h80);
    imem[32'h200 >> 2] = enc_j(6'h03, 26'hC0);
    imem[32'h300 >> 2] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    start();
    cyc(10);
    ncmp++; if (imem_addr !== 32'h104) begin nerr++; $display("FAIL bne_not_taken: got %h want 104", imem_addr); end
    cyc(10);
    ncmp++; if (imem_addr !== 32'h300) begin nerr++; $display("FAIL jal_target: got %h want 300", imem_addr); end
    ncmp++; if (dut.regs[31] !== 32'h204) begin nerr++; $display("FAIL jal_link: got %h want 204", dut.regs[31]); end
    cyc(5);
    ncmp++; if (imem_addr !== 32'h204) begin nerr++; $display("FAIL jr_return: got %h want 204", imem_addr); end
  endtask

  task automatic test_illegal();
    clear_prog();
    imem[32'h400 >> 2] = enc_i(6'h09, 5'd0, 5'd1, 16'h0009);
    imem[32'h404 >> 2] = 32'hFC221234;
    start();
    cyc(8);
    ncmp++; if (illegal !== 1'b0) begin nerr++; $display("FAIL ill_pre: got %b want 0", illegal); end
    cyc(1);
    ncmp++; if (illegal !== 1'b1) begin nerr++; $display("FAIL ill_wb: got %b want 1", illegal); end
    cyc(1);
    ncmp++; if (illegal !== 1'b0 || ill_cnt !== 1) begin nerr++; $display("FAIL ill_pulse: got lvl=%b cnt=%0d want 0/1", illegal, ill_cnt); end
    ncmp++; if (imem_addr !== 32'h408 || retired !== 32'd2) begin nerr++; $display("FAIL ill_advance: got pc=%h ret=%0d want 408/2", imem_addr, retired); end
    ncmp++; if (dut.regs[1] !== 32'h9 || dut.regs[2] !== 32'h0) begin nerr++; $display("FAIL ill_regs: got r1=%h r2=%h want 9/0", dut.regs[1], dut.regs[2]); end
  endtask

  task automatic test_reset_mid_mem();
    clear_prog();
    imem[32'h400 >> 2] = enc_i(6'h2B, 5'd0, 5'd29, 16'h0008);
    dmem_lat = 5;
    start();
    cyc(6);
    ncmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin nerr++; $display("FAIL mid_sw_req: got req=%b we=%b want 1/1", dmem_req, dmem_we); end
    reset = 1'b1;
    #1;
    ncmp++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL mid_rst_req: got %b want 0", dmem_req); end
    cyc(1);
    reset = 1'b0;
    #1;
    ncmp++; if (st_cnt !== 0 || retired !== 32'd0) begin nerr++; $display("FAIL mid_rst_abort: got st=%0d ret=%0d want 0/0", st_cnt, retired); end
    ncmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin nerr++; $display("FAIL mid_rst_pc: got req=%b addr=%h want 1/400", imem_req, imem_addr); end
    cyc(13);
    ncmp++; if (st_cnt !== 1 || st_data[0] !== 32'h7FFC || st_addr[0] !== 32'h8) begin nerr++; $display("FAIL mid_rst_rerun: got n=%0d %h@%h want 1 00007ffc@8", st_cnt, st_data[0], st_addr[0]); end
    ncmp++; if (retired !== 32'd1) begin nerr++; $display("FAIL mid_rst_retired: got %0d want 1", retired); end
    dmem_lat = 0;
  endtask

  initial begin
    reset = 1'b1; tb_clr = 1'b1;
    imem_lat = 0; dmem_lat = 0; ld_data = 32'h0;
    icnt = 0; dcnt = 0; st_cnt = 0; ill_cnt = 0; overlap = 0;
    test_reset();
    test_slt();
    test_alu();
    test_wait_states();
    test_branches();
    test_illegal();
    test_reset_mid_mem();
    ncmp++; if (overlap !== 0) begin nerr++; $display("FAIL req_overlap: got %0d want 0", overlap); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
`default_nettype wire
